// File: rtl/fp_pkg.sv
// Shared types and binary32 constants for the adder post-normalization stage.
package fp_pkg;

  localparam int FP_EXP_W      = 8;
  localparam int FP_FRAC_W     = 23;
  localparam int FP_RAW_MANT_W = 27;
  localparam logic [FP_EXP_W-1:0] FP_EXP_INF = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SHIFT,
    ST_ROUND,
    ST_DONE
  } post_norm_state_t;

  function automatic logic [31:0] fp_pack_inf(input logic sign);
    return {sign, FP_EXP_INF, {FP_FRAC_W{1'b0}}};
  endfunction

endpackage

// File: rtl/fp_add_post_norm_if.sv
// Raw-result input and packed-result output handshake bundle for fp_add_post_norm.
interface fp_add_post_norm_if;
  import fp_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic                     in_sign;
  logic [FP_EXP_W-1:0]      in_exp;
  logic [FP_RAW_MANT_W-1:0] in_mant;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_result;
  logic                     out_ovf;
  logic                     out_unf;
  logic                     out_inexact;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out_result, out_ovf, out_unf, out_inexact
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out_result, out_ovf, out_unf, out_inexact
  );

endinterface

// File: rtl/fp_lzc26.sv
// Combinational 26-bit leading-zero counter (26 when all zero).
// Only compiled when FP_POST_NORM_FAST_LZC_EN is defined.
`ifdef FP_POST_NORM_FAST_LZC_EN
module fp_lzc26 (
  input  logic [25:0] in_bits,
  output logic [4:0]  lzc
);

  // Ascending scan: the highest set bit is the last one to write lzc.
  always_comb begin
    lzc = 5'd26;
    for (int i = 0; i < 26; i++) begin
      if (in_bits[i]) begin
        lzc = 5'(25 - i);
      end
    end
  end

endmodule
`endif

// File: rtl/fp_add_post_norm.sv
// Post-normalization, RNE rounding and binary32 packing after the FP adder.
// Define FP_POST_NORM_FAST_LZC_EN to normalize in one cycle with fp_lzc26.
module fp_add_post_norm
  import fp_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  fp_add_post_norm_if.slave bus
);

  localparam logic [8:0] EXP_INF9  = {1'b0, FP_EXP_INF};
  localparam logic [4:0] SHIFT_MAX = 5'd24;

  post_norm_state_t state_q, state_d;
  logic        sign_q, sign_d;
  logic [8:0]  exp_q, exp_d;
  logic [26:0] mant_q, mant_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] result_q, result_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic        inexact_q, inexact_d;

  logic [26:0] mant_rsh;
  logic [8:0]  exp_inc;
  logic        rnd_inc;
  logic [24:0] sig_sum;

`ifdef FP_POST_NORM_FAST_LZC_EN
  logic [4:0]  lzc;
  logic [8:0]  exp_lim;
  logic [8:0]  fast_amt;
  logic [24:0] fast_body;

  // Sticky is excluded from the count; it never moves during normalization.
  fp_lzc26 u_lzc (
    .in_bits ({mant_q[25:1], 1'b0}),
    .lzc     (lzc)
  );

  always_comb begin
    exp_lim  = (exp_q > 9'd1) ? exp_q - 9'd1 : 9'd0;
    fast_amt = ({4'd0, lzc} < exp_lim) ? {4'd0, lzc} : exp_lim;
    if (fast_amt > {4'd0, SHIFT_MAX}) begin
      fast_amt = {4'd0, SHIFT_MAX};
    end
    fast_body = mant_q[25:1] << fast_amt;
  end
`endif

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    mant_d      = mant_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    inexact_d   = inexact_q;

    mant_rsh = {1'b0, mant_q[26:2], mant_q[1] | mant_q[0]};
    exp_inc  = exp_q + 9'd1;
    rnd_inc  = mant_q[1] & (mant_q[0] | mant_q[2]);
    sig_sum  = {1'b0, mant_q[25:2]} + {24'd0, rnd_inc};

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          sign_d     = bus.in_sign;
          exp_d      = {1'b0, bus.in_exp};
          mant_d     = bus.in_mant;
          in_ready_d = 1'b0;
          state_d    = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (exp_q == EXP_INF9) begin
          result_d    = {sign_q, FP_EXP_INF, mant_q[24:2]};
          ovf_d       = 1'b0;
          unf_d       = 1'b0;
          inexact_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else if (mant_q == '0) begin
          result_d    = '0;
          ovf_d       = 1'b0;
          unf_d       = 1'b0;
          inexact_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else if (mant_q[26]) begin
          mant_d = mant_rsh;
          exp_d  = exp_inc;
          if (exp_inc == EXP_INF9) begin
            result_d    = fp_pack_inf(sign_q);
            ovf_d       = 1'b1;
            unf_d       = 1'b0;
            inexact_d   = mant_rsh[1] | mant_rsh[0];
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            state_d = ST_ROUND;
          end
        end else begin
`ifdef FP_POST_NORM_FAST_LZC_EN
          mant_d  = {1'b0, fast_body, mant_q[0]};
          exp_d   = exp_q - fast_amt;
          state_d = ST_ROUND;
`else
          if (!mant_q[25] && exp_q > 9'd1) begin
            cnt_d   = '0;
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_ROUND;
          end
`endif
        end
      end

      // Guard shifts into the significand; sticky stays pinned at bit 0.
      ST_SHIFT: begin
        mant_d = {1'b0, mant_q[24:1], 1'b0, mant_q[0]};
        exp_d  = exp_q - 9'd1;
        cnt_d  = cnt_q + 5'd1;
        if (mant_d[25] || exp_d == 9'd1 || cnt_d == SHIFT_MAX) begin
          state_d = ST_ROUND;
        end
      end

      ST_ROUND: begin
        inexact_d = mant_q[1] | mant_q[0];
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
        if (sig_sum[24]) begin
          if (exp_inc == EXP_INF9) begin
            result_d = fp_pack_inf(sign_q);
            ovf_d    = 1'b1;
          end else begin
            result_d = {sign_q, exp_inc[7:0], 23'd0};
          end
        end else if (sig_sum[23]) begin
          result_d = {sign_q, exp_q[7:0], sig_sum[22:0]};
        end else begin
          result_d = {sign_q, 8'd0, sig_sum[22:0]};
          unf_d    = mant_q[1] | mant_q[0];
        end
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end

      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inexact_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      inexact_q   <= inexact_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = result_q;
  assign bus.out_ovf     = ovf_q;
  assign bus.out_unf     = unf_q;
  assign bus.out_inexact = inexact_q;

endmodule

// File: tb/tb_fp_add_post_norm.sv
// Directed self-checking bench for fp_add_post_norm with hand-computed vectors.
module tb_fp_add_post_norm;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

`ifdef FP_POST_NORM_FAST_LZC_EN
  localparam int LAT_CANCEL = 3;
  localparam int LAT_DENORM = 3;
`else
  localparam int LAT_CANCEL = 26;
  localparam int LAT_DENORM = 5;
`endif

  fp_add_post_norm_if bus_if ();

  fp_add_post_norm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Waits for in_ready, presents one raw result and returns just after the acceptance edge.
  task automatic applyStimulus(input string tag, input logic s, input logic [7:0] e,
                               input logic [26:0] m);
    int waited;
    waited = 0;
    while (bus_if.in_ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    checkValue({tag, ".in_ready"}, {31'd0, bus_if.in_ready}, 32'd1);
    bus_if.in_valid = 1'b1;
    bus_if.in_sign  = s;
    bus_if.in_exp   = e;
    bus_if.in_mant  = m;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
  endtask

  task automatic waitValid(output int lat);
    lat = 1;
    while (bus_if.out_valid !== 1'b1 && lat < 80) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] xres, input logic xovf,
                             input logic xunf, input logic xinx, input int xlat, input int lat);
    checkValue({tag, ".latency"}, lat, xlat);
    checkValue({tag, ".result"}, bus_if.out_result, xres);
    checkValue({tag, ".ovf"}, {31'd0, bus_if.out_ovf}, {31'd0, xovf});
    checkValue({tag, ".unf"}, {31'd0, bus_if.out_unf}, {31'd0, xunf});
    checkValue({tag, ".inexact"}, {31'd0, bus_if.out_inexact}, {31'd0, xinx});
  endtask

  task automatic consume();
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic s, input logic [7:0] e, input logic [26:0] m,
                       input logic [31:0] xres, input logic xovf, input logic xunf,
                       input logic xinx, input int xlat);
    int lat;
    applyStimulus(tag, s, e, m);
    waitValid(lat);
    checkOutput(tag, xres, xovf, xunf, xinx, xlat, lat);
    consume();
  endtask

  initial begin
    int  lat;
    logic seen;
    errors = 0;
    checks = 0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_sign   = 1'b0;
    bus_if.in_exp    = '0;
    bus_if.in_mant   = '0;
    bus_if.out_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checkValue("reset.in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    checkValue("reset.out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    checkValue("reset.result", bus_if.out_result, 32'd0);
    checkValue("reset.flags", {29'd0, bus_if.out_ovf, bus_if.out_unf, bus_if.out_inexact}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    runOp("one",       1'b0, 8'd127, 27'h2000000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 3);
    runOp("carry",     1'b0, 8'd127, 27'h4000000, 32'h40000000, 1'b0, 1'b0, 1'b0, 3);
    runOp("ovf_chk",   1'b0, 8'd254, 27'h4000000, 32'h7F800000, 1'b1, 1'b0, 1'b0, 2);
    runOp("cancel",    1'b0, 8'd130, 27'h0000004, 32'h35800000, 1'b0, 1'b0, 1'b0, LAT_CANCEL);
    runOp("zero",      1'b1, 8'd100, 27'h0000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 2);
    runOp("denorm",    1'b0, 8'd3,   27'h0400000, 32'h00400000, 1'b0, 1'b0, 1'b0, LAT_DENORM);
    runOp("denorm_st", 1'b0, 8'd3,   27'h0400001, 32'h00400000, 1'b0, 1'b1, 1'b1, LAT_DENORM);
    runOp("rne_tie0",  1'b0, 8'd127, 27'h2000002, 32'h3F800000, 1'b0, 1'b0, 1'b1, 3);
    runOp("rne_tie1",  1'b0, 8'd127, 27'h2000006, 32'h3F800002, 1'b0, 1'b0, 1'b1, 3);
    runOp("rne_carry", 1'b0, 8'd127, 27'h3FFFFFE, 32'h40000000, 1'b0, 1'b0, 1'b1, 3);
    runOp("bypass",    1'b1, 8'd255, 27'h0400008, 32'hFF900002, 1'b0, 1'b0, 1'b0, 2);
    runOp("negative",  1'b1, 8'd128, 27'h2800000, 32'hC0200000, 1'b0, 1'b0, 1'b0, 3);
    runOp("sub2norm",  1'b0, 8'd1,   27'h1FFFFFE, 32'h00800000, 1'b0, 1'b0, 1'b1, 3);
    runOp("ovf_rnd",   1'b0, 8'd254, 27'h3FFFFFE, 32'h7F800000, 1'b1, 1'b0, 1'b1, 3);

    // Back-pressure: DONE must hold its result while out_ready stays low.
    applyStimulus("hold", 1'b0, 8'd127, 27'h2000006);
    waitValid(lat);
    checkValue("hold.latency", lat, 3);
    for (int i = 0; i < 5; i++) begin
      checkValue($sformatf("hold%0d.result", i), bus_if.out_result, 32'h3F800002);
      checkValue($sformatf("hold%0d.valid", i), {31'd0, bus_if.out_valid}, 32'd1);
      checkValue($sformatf("hold%0d.in_ready", i), {31'd0, bus_if.in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    consume();
    checkValue("hold.release.valid", {31'd0, bus_if.out_valid}, 32'd0);
    checkValue("hold.release.in_ready", {31'd0, bus_if.in_ready}, 32'd1);

    // Reset while normalizing: the operation is dropped without output.
    applyStimulus("abort", 1'b0, 8'd130, 27'h0000004);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkValue("abort.in_ready_rst", {31'd0, bus_if.in_ready}, 32'd1);
    seen = bus_if.out_valid;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      seen = seen | bus_if.out_valid;
    end
    checkValue("abort.no_valid", {31'd0, seen}, 32'd0);
    checkValue("abort.in_ready", {31'd0, bus_if.in_ready}, 32'd1);

    runOp("after_abort", 1'b0, 8'd127, 27'h2000000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
